tdc_peak_select: RTL and testbench

TDC_PEAK_SELECT -- requirements
Module: tdc_peak_select

---
 rtl/tdc_pkg.sv | 24 ++
 rtl/tdc_peak_cmp.sv | 35 +++
 rtl/tdc_peak_select.sv | 166 ++++++++++++++++
 tb/tb_tdc_peak_select.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared widths, FSM state encoding and result payload for the TDC peak selector.
package tdc_pkg;

    localparam int unsigned TDC_DEPTH_W   = 15;
    localparam int unsigned TDC_INT_W     = 4;
    localparam int unsigned TDC_MAX_BEATS = 4;
    localparam int unsigned TDC_CNT_W     = 3;
    localparam int unsigned TDC_STAT_W    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } tdc_state_e;

    typedef struct packed {
        logic [TDC_DEPTH_W-1:0] depth;
        logic [TDC_INT_W-1:0]   intensity;
        logic [TDC_CNT_W-1:0]   cnt;
        logic                   hit;
        logic                   ovf;
    } tdc_result_t;

endpackage

// File: rtl/tdc_peak_cmp.sv
// Combinational compare of one beat against the running best; earliest beat wins ties.
module tdc_peak_cmp
    import tdc_pkg::*;
#(
    parameter logic [TDC_INT_W-1:0] INT_MIN = 4'd1
) (
    input  logic [TDC_DEPTH_W-1:0] beat_depth,
    input  logic [TDC_INT_W-1:0]   beat_int,
    input  logic [TDC_DEPTH_W-1:0] best_depth,
    input  logic [TDC_INT_W-1:0]   best_int,
    input  logic                   best_hit,
    output logic                   qual_c,
    output logic [TDC_DEPTH_W-1:0] sel_depth_c,
    output logic [TDC_INT_W-1:0]   sel_int_c,
    output logic                   sel_hit_c
);

    logic take;

    // Strictly greater keeps the earlier beat on equal intensity.
    assign qual_c = (beat_int >= INT_MIN);
    assign take   = qual_c && (!best_hit || (beat_int > best_int));

    always_comb begin
        sel_depth_c = best_depth;
        sel_int_c   = best_int;
        sel_hit_c   = best_hit;
        if (take) begin
            sel_depth_c = beat_depth;
            sel_int_c   = beat_int;
            sel_hit_c   = 1'b1;
        end
    end

endmodule

// File: rtl/tdc_peak_select.sv
// Per-packet peak selector for the TDC stream: keeps the strongest qualifying beat.
// Optional TDC_PEAK_STATS_EN adds saturating result/miss counters.
module tdc_peak_select
    import tdc_pkg::*;
#(
    parameter logic [TDC_INT_W-1:0]   INT_MIN     = 4'd1,
    parameter logic [TDC_DEPTH_W-1:0] NO_HIT_CODE = 15'h7FFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TDC_DEPTH_W-1:0] s_data,
    input  logic [TDC_INT_W-1:0]   s_int,
    input  logic [1:0]             s_num,
    input  logic                   s_last,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [TDC_DEPTH_W-1:0] r_depth,
    output logic [TDC_INT_W-1:0]   r_int,
    output logic [TDC_CNT_W-1:0]   r_cnt,
    output logic                   r_hit,
    output logic                   r_ovf,
    output logic                   r_valid,
    input  logic                   r_ready
`ifdef TDC_PEAK_STATS_EN
    ,
    output logic [TDC_STAT_W-1:0]  stat_pkts,
    output logic [TDC_STAT_W-1:0]  stat_miss
`endif
);

    tdc_state_e state_q, state_d;

    logic                   rdy_q;
    logic                   r_valid_q;
    tdc_result_t            res_q, res_d;

    logic [TDC_DEPTH_W-1:0] acc_depth_q, base_depth;
    logic [TDC_INT_W-1:0]   acc_int_q, base_int;
    logic [TDC_CNT_W-1:0]   acc_cnt_q, base_cnt, cnt_d;
    logic [TDC_CNT_W-1:0]   acc_beats_q, base_beats, beats_d;
    logic                   acc_hit_q, base_hit;
    logic [1:0]             pkt_num_unused;

    logic                   first_beat;
    logic                   beat_fire;
    logic                   res_fire;
    logic                   qual;
    logic [TDC_DEPTH_W-1:0] sel_depth;
    logic [TDC_INT_W-1:0]   sel_int;
    logic                   sel_hit;

    // While a result waits, input is accepted only in the cycle the result leaves.
    assign s_ready    = rdy_q && ((state_q != EMIT) || r_ready);
    assign beat_fire  = s_valid && s_ready;
    assign res_fire   = r_valid_q && r_ready;
    assign first_beat = (state_q != COLLECT);

    assign base_depth = first_beat ? '0 : acc_depth_q;
    assign base_int   = first_beat ? '0 : acc_int_q;
    assign base_cnt   = first_beat ? '0 : acc_cnt_q;
    assign base_beats = first_beat ? '0 : acc_beats_q;
    assign base_hit   = first_beat ? 1'b0 : acc_hit_q;

    tdc_peak_cmp #(
        .INT_MIN    (INT_MIN)
    ) u_cmp (
        .beat_depth (s_data),
        .beat_int   (s_int),
        .best_depth (base_depth),
        .best_int   (base_int),
        .best_hit   (base_hit),
        .qual_c     (qual),
        .sel_depth_c(sel_depth),
        .sel_int_c  (sel_int),
        .sel_hit_c  (sel_hit)
    );

    // Counters saturate; beat count stops one past the limit to flag overflow.
    always_comb begin
        cnt_d   = base_cnt;
        beats_d = base_beats;
        if (qual && (base_cnt < TDC_CNT_W'(TDC_MAX_BEATS)))
            cnt_d = base_cnt + TDC_CNT_W'(1);
        if (base_beats <= TDC_CNT_W'(TDC_MAX_BEATS))
            beats_d = base_beats + TDC_CNT_W'(1);
    end

    always_comb begin
        res_d.depth     = sel_hit ? sel_depth : NO_HIT_CODE;
        res_d.intensity = sel_int;
        res_d.cnt       = cnt_d;
        res_d.hit       = sel_hit;
        res_d.ovf       = (beats_d > TDC_CNT_W'(TDC_MAX_BEATS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (beat_fire && s_last)  state_d = EMIT;
                else if (beat_fire)       state_d = COLLECT;
            end
            EMIT: begin
                if (beat_fire)            state_d = s_last ? EMIT : COLLECT;
                else if (res_fire)        state_d = IDLE;
            end
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q          <= 1'b0;
            r_valid_q      <= 1'b0;
            res_q          <= '0;
            acc_depth_q    <= '0;
            acc_int_q      <= '0;
            acc_cnt_q      <= '0;
            acc_beats_q    <= '0;
            acc_hit_q      <= 1'b0;
            pkt_num_unused <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (beat_fire) begin
                acc_depth_q <= sel_depth;
                acc_int_q   <= sel_int;
                acc_cnt_q   <= cnt_d;
                acc_beats_q <= beats_d;
                acc_hit_q   <= sel_hit;
                if (first_beat) pkt_num_unused <= s_num;
            end
            if (beat_fire && s_last) begin
                res_q     <= res_d;
                r_valid_q <= 1'b1;
            end else if (res_fire) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    assign r_depth = res_q.depth;
    assign r_int   = res_q.intensity;
    assign r_cnt   = res_q.cnt;
    assign r_hit   = res_q.hit;
    assign r_ovf   = res_q.ovf;
    assign r_valid = r_valid_q;

`ifdef TDC_PEAK_STATS_EN
    // Accepted-result and no-hit counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkts <= '0;
            stat_miss <= '0;
        end else if (res_fire) begin
            if (stat_pkts != '1)               stat_pkts <= stat_pkts + TDC_STAT_W'(1);
            if (!res_q.hit && stat_miss != '1) stat_miss <= stat_miss + TDC_STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tdc_peak_select.sv
// Scoreboard bench for tdc_peak_select: expected results queued per packet, popped on transfer.
module tb_tdc_peak_select;
    import tdc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] s_data;
    logic [3:0]  s_int;
    logic [1:0]  s_num;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [14:0] r_depth;
    logic [3:0]  r_int;
    logic [2:0]  r_cnt;
    logic        r_hit;
    logic        r_ovf;
    logic        r_valid;
    logic        r_ready;
`ifdef TDC_PEAK_STATS_EN
    logic [15:0] stat_pkts;
    logic [15:0] stat_miss;
`endif

    always #2 clk = ~clk;

    tdc_peak_select dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_data (s_data),
        .s_int  (s_int),
        .s_num  (s_num),
        .s_last (s_last),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .r_depth(r_depth),
        .r_int  (r_int),
        .r_cnt  (r_cnt),
        .r_hit  (r_hit),
        .r_ovf  (r_ovf),
        .r_valid(r_valid),
        .r_ready(r_ready)
`ifdef TDC_PEAK_STATS_EN
        ,
        .stat_pkts(stat_pkts),
        .stat_miss(stat_miss)
`endif
    );

    int          n_vec = 0;
    int          n_err = 0;
    tdc_result_t exp_q[$];
    logic [14:0] pd[16];
    logic [3:0]  pi[16];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference selection over the first n entries of pd/pi.
    function automatic tdc_result_t model(input int n);
        tdc_result_t e;
        int q;
        e = '0;
        e.depth = 15'h7FFF;
        q = 0;
        for (int i = 0; i < n; i++) begin
            if (pi[i] >= 4'd1) begin
                q++;
                if (!e.hit || pi[i] > e.intensity) begin
                    e.hit = 1'b1;
                    e.depth = pd[i];
                    e.intensity = pi[i];
                end
            end
        end
        e.cnt = (q > 4) ? 3'd4 : 3'(q);
        e.ovf = (n > 4);
        return e;
    endfunction

    task automatic drive_beat(input logic [14:0] d, input logic [3:0] it, input logic last);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_int   = it;
        s_last  = last;
        s_num   = 2'($urandom_range(0, 3));
        @(negedge clk);
        while (!s_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        check_val("beat_accept", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send(input int n);
        exp_q.push_back(model(n));
        for (int i = 0; i < n; i++) drive_beat(pd[i], pi[i], (i == n - 1));
    endtask

    // Result monitor: transfer happens on the next rising edge.
    always @(negedge clk) begin
        tdc_result_t e;
        if (rst_n && r_valid && r_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("r_depth", 32'(r_depth), 32'(e.depth));
                check_val("r_int",   32'(r_int),   32'(e.intensity));
                check_val("r_cnt",   32'(r_cnt),   32'(e.cnt));
                check_val("r_hit",   32'(r_hit),   32'(e.hit));
                check_val("r_ovf",   32'(r_ovf),   32'(e.ovf));
            end
        end
    end

    initial begin
        tdc_result_t eb;
        int n;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_int = '0; s_num = '0;
        s_last = 1'b0; r_ready = 1'b1;
        #5;
        check_val("rst_s_ready", 32'(s_ready), 32'd0);
        check_val("rst_r_valid", 32'(r_valid), 32'd0);
        check_val("rst_r_depth", 32'(r_depth), 32'd0);
        check_val("rst_r_int",   32'(r_int),   32'd0);
        check_val("rst_r_cnt",   32'(r_cnt),   32'd0);
        check_val("rst_r_hit",   32'(r_hit),   32'd0);
        check_val("rst_r_ovf",   32'(r_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("s_ready_before_edge", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        check_val("s_ready_after_edge", 32'(s_ready), 32'd1);

        // Basic three-beat packet
        pd[0] = 15'd100; pd[1] = 15'd200; pd[2] = 15'd300;
        pi[0] = 4'd2;    pi[1] = 4'd7;    pi[2] = 4'd5;
        send(3);
        check_val("basic_latency", 32'(r_valid), 32'd1);
        check_val("basic_depth",   32'(r_depth), 32'd200);
        check_val("basic_int",     32'(r_int),   32'd7);
        check_val("basic_cnt",     32'(r_cnt),   32'd3);

        // Single non-qualifying beat, back-to-back with previous result
        pd[0] = 15'd123; pi[0] = 4'd0;
        send(1);
        check_val("nohit_hit",   32'(r_hit),   32'd0);
        check_val("nohit_depth", 32'(r_depth), 32'h7FFF);
        check_val("nohit_cnt",   32'(r_cnt),   32'd0);

        // Overlong packet, peak on the last beat
        pd[0] = 15'd10; pd[1] = 15'd20; pd[2] = 15'd30;
        pd[3] = 15'd40; pd[4] = 15'd50; pd[5] = 15'd55;
        pi[0] = 4'd1;   pi[1] = 4'd3;   pi[2] = 4'd0;
        pi[3] = 4'd2;   pi[4] = 4'd4;   pi[5] = 4'd9;
        send(6);
        check_val("ovf_depth", 32'(r_depth), 32'd55);
        check_val("ovf_cnt",   32'(r_cnt),   32'd4);
        check_val("ovf_flag",  32'(r_ovf),   32'd1);

        // Random packets; narrow intensity range half the time to force ties
        for (int p = 0; p < 20; p++) begin
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                pd[i] = 15'($urandom);
                pi[i] = (p % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            end
            send(n);
        end

        // Backpressure hold, then result and next beat in the same cycle
        @(posedge clk); #1;
        r_ready = 1'b0;
        pd[0] = 15'd77; pd[1] = 15'd88;
        pi[0] = 4'd3;   pi[1] = 4'd3;
        send(2);
        pd[0] = 15'd999; pi[0] = 4'd6;
        eb = model(1);
        exp_q.push_back(eb);
        s_valid = 1'b1; s_data = pd[0]; s_int = pi[0]; s_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("hold_s_ready", 32'(s_ready), 32'd0);
            check_val("hold_r_valid", 32'(r_valid), 32'd1);
            check_val("hold_r_depth", 32'(r_depth), 32'd77);
            check_val("hold_r_cnt",   32'(r_cnt),   32'd2);
        end
        @(posedge clk); #1;
        r_ready = 1'b1;
        @(negedge clk);
        check_val("release_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        check_val("nobubble_valid", 32'(r_valid), 32'd1);
        check_val("nobubble_depth", 32'(r_depth), 32'd999);

        // Reset in the middle of a packet
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive_beat(15'd500, 4'd9, 1'b0);
        drive_beat(15'd600, 4'd10, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("midrst_r_valid", 32'(r_valid), 32'd0);
        check_val("midrst_s_ready", 32'(s_ready), 32'd0);
        check_val("midrst_r_cnt",   32'(r_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("no_stale", 32'(r_valid), 32'd0);
        end
        pd[0] = 15'd1; pd[1] = 15'd2; pd[2] = 15'd3;
        pi[0] = 4'd4;  pi[1] = 4'd8;  pi[2] = 4'd8;
        send(3);
        pd[0] = 15'd9; pi[0] = 4'd0;
        send(1);
        pd[0] = 15'd11; pd[1] = 15'd12;
        pi[0] = 4'd0;   pi[1] = 4'd15;
        send(2);
        repeat (4) @(posedge clk);
        #1;
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef TDC_PEAK_STATS_EN
        check_val("stat_pkts", 32'(stat_pkts), 32'd3);
        check_val("stat_miss", 32'(stat_miss), 32'd1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
